// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue controller for the single shared iterative divider in EX.
// Serialises DIV/DIVU requests from issue lane 1 (older) and lane 2 onto the divider,
// returns lane-tagged HI/LO results and stalls the pipeline until all work is done.
// Optional watchdog: define DIV_TIMEOUT_EN to abort a divide that never reports ready.
module div_issue_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_i1,
    input  logic        signed_i1,
    input  logic [31:0] opa_i1,
    input  logic [31:0] opb_i1,
    input  logic        req_i2,
    input  logic        signed_i2,
    input  logic [31:0] opa_i2,
    input  logic [31:0] opb_i2,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        res_valid_o,
    output logic        res_lane_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_for_div,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Quotient reported for a zero divisor (remainder is the dividend).
    localparam logic [31:0] QUOT_DIV0 = 32'hFFFF_FFFF;

    state_t      state_r;
    logic        pending_r;
    logic        buf_signed_r;
    logic [31:0] buf_opa_r;
    logic [31:0] buf_opb_r;

    logic        sel_lane_s;
    logic        sel_signed_s;
    logic [31:0] sel_opa_s;
    logic [31:0] sel_opb_s;
    logic        stall_s;

`ifdef DIV_TIMEOUT_EN
    // The abort strobes are registered, so they fire at the end of the cycle
    // before the limit; they become visible exactly TIMEOUT cycles after start.
    localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT - 2);
    logic [5:0] wdog_r;
    logic       timeout_r;
    assign timeout_o = timeout_r;
`else
    // Watchdog compiled out: strobe is constant low, TIMEOUT has no effect.
    assign timeout_o = 1'b0 & (TIMEOUT == 0);
`endif

    // Pick the request to serve first: lane 1 is older and always wins.
    always_comb begin
        sel_lane_s   = 1'b0;
        sel_signed_s = signed_i1;
        sel_opa_s    = opa_i1;
        sel_opb_s    = opb_i1;
        if (req_i1) begin
            sel_lane_s   = 1'b0;
            sel_signed_s = signed_i1;
            sel_opa_s    = opa_i1;
            sel_opb_s    = opb_i1;
        end else begin
            sel_lane_s   = 1'b1;
            sel_signed_s = signed_i2;
            sel_opa_s    = opa_i2;
            sel_opb_s    = opb_i2;
        end
    end

    // Stall must react in the request cycle itself, so it is decoded from state.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = (req_i1 | req_i2) & ~flush;
            START:   stall_s = 1'b1;
            WAIT:    stall_s = 1'b1;
            DONE:    stall_s = pending_r;
            default: stall_s = 1'b0;
        endcase
    end

    assign stallreq_for_div = stall_s;

    // Control FSM with registered divider handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pending_r    <= 1'b0;
            buf_signed_r <= 1'b0;
            buf_opa_r    <= 32'd0;
            buf_opb_r    <= 32'd0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_opa_o    <= 32'd0;
            div_opb_o    <= 32'd0;
            res_valid_o  <= 1'b0;
            res_lane_o   <= 1'b0;
            hi_o         <= 32'd0;
            lo_o         <= 32'd0;
`ifdef DIV_TIMEOUT_EN
            wdog_r       <= 6'd0;
            timeout_r    <= 1'b0;
`endif
        end else begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b0;
            res_valid_o <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            timeout_r   <= 1'b0;
`endif
            if (flush) begin
                // Flush wins over everything; a ready in this cycle is dropped.
                state_r   <= IDLE;
                pending_r <= 1'b0;
                if (state_r == WAIT) begin
                    div_annul_o <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (req_i1 | req_i2) begin
                            pending_r    <= req_i1 & req_i2;
                            buf_signed_r <= signed_i2;
                            buf_opa_r    <= opa_i2;
                            buf_opb_r    <= opb_i2;
                            res_lane_o   <= sel_lane_s;
                            if (sel_opb_s == 32'd0) begin
                                hi_o        <= sel_opa_s;
                                lo_o        <= QUOT_DIV0;
                                res_valid_o <= 1'b1;
                                state_r     <= DONE;
                            end else begin
                                div_signed_o <= sel_signed_s;
                                div_opa_o    <= sel_opa_s;
                                div_opb_o    <= sel_opb_s;
                                div_start_o  <= 1'b1;
                                state_r      <= START;
                            end
                        end
                    end
                    START: begin
`ifdef DIV_TIMEOUT_EN
                        wdog_r <= 6'd0;
`endif
                        state_r <= WAIT;
                    end
                    WAIT: begin
                        if (div_ready_i) begin
                            hi_o        <= div_result_i[63:32];
                            lo_o        <= div_result_i[31:0];
                            res_valid_o <= 1'b1;
                            state_r     <= DONE;
                        end
`ifdef DIV_TIMEOUT_EN
                        else if (wdog_r == WDOG_LAST) begin
                            hi_o        <= 32'd0;
                            lo_o        <= 32'd0;
                            res_valid_o <= 1'b1;
                            div_annul_o <= 1'b1;
                            timeout_r   <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            wdog_r <= wdog_r + 6'd1;
                        end
`endif
                    end
                    DONE: begin
                        if (pending_r) begin
                            pending_r  <= 1'b0;
                            res_lane_o <= 1'b1;
                            if (buf_opb_r == 32'd0) begin
                                hi_o        <= buf_opa_r;
                                lo_o        <= QUOT_DIV0;
                                res_valid_o <= 1'b1;
                                state_r     <= DONE;
                            end else begin
                                div_signed_o <= buf_signed_r;
                                div_opa_o    <= buf_opa_r;
                                div_opb_o    <= buf_opb_r;
                                div_start_o  <= 1'b1;
                                state_r      <= START;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        pending_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Controls the single shared iterative divider for both issue lanes of the dual-issue pipeline, and sits in EX.
- Accepts DIV/DIVU requests from lane 1 (older instruction) and lane 2, serialises them onto the divider with a start/ready handshake, and returns HI/LO results tagged by lane.
- Holds a stall request to the pipeline controller until every pending division has completed. Cancels in-flight work on flush.

Parameters:
- TIMEOUT, 40, watchdog limit in cycles from div_start_o to div_ready_i. Used only when DIV_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush (exception/ERET); cancels all work
- req_i1  input  1  lane-1 divide request, held stable while stalled
- signed_i1  input  1  lane-1 signed (DIV) = 1, unsigned (DIVU) = 0
- opa_i1  input  32  lane-1 dividend
- opb_i1  input  32  lane-1 divisor
- req_i2  input  1  lane-2 divide request
- signed_i2  input  1  lane-2 signedness
- opa_i2  input  32  lane-2 dividend
- opb_i2  input  32  lane-2 divisor
- div_start_o  output  1  one-cycle start pulse to the divider
- div_annul_o  output  1  one-cycle abort pulse to the divider
- div_signed_o  output  1  signedness presented to the divider
- div_opa_o  output  32  dividend presented to the divider
- div_opb_o  output  32  divisor presented to the divider
- div_ready_i  input  1  divider result valid (one-cycle pulse)
- div_result_i  input  64  {remainder, quotient}
- res_valid_o  output  1  result strobe, one cycle
- res_lane_o  output  1  0 = lane 1, 1 = lane 2
- hi_o  output  32  remainder
- lo_o  output  32  quotient
- stallreq_for_div  output  1  stall request to the pipeline controller
- timeout_o  output  1  watchdog abort strobe (0 when the feature is off)

Behaviour:
- States: IDLE, START, WAIT, DONE.
- Reset: state IDLE, pending_i2 = 0. All outputs 0, including the operand registers.
- IDLE, with a request present and no flush:
  - Latch the operands of lane 1 if req_i1, else lane 2.
  - If both lanes request, set pending_i2 and latch lane-2 operands into a second buffer.
  - Divisor == 0: go to DONE directly with hi = opa, lo = 32'hFFFFFFFF. No divider start.
  - Otherwise go to START.
- START: div_start_o = 1 for exactly one cycle; div_* operand outputs are driven from the latch; go to WAIT.
- WAIT: on div_ready_i, capture div_result_i into {hi_o, lo_o} and go to DONE. div_opa_o, div_opb_o and div_signed_o stay stable through WAIT.
- DONE: res_valid_o = 1 with res_lane_o set.
  - If pending_i2: load the lane-2 buffer, clear pending_i2, and go to START (or back to DONE if the divisor is 0).
  - Else go to IDLE.
- stallreq_for_div = 1 when:
  - in IDLE with (req_i1 | req_i2) and no flush; or
  - in START or WAIT; or
  - in DONE with pending_i2.
- stallreq_for_div = 0 in DONE with no pending request, so the pipeline advances on the same cycle the result is delivered.
- Requests are sampled only in IDLE. A request still held during DONE is never restarted.
- Minimum latency from request to res_valid_o: 2 + divider latency. Divide by zero takes 1 cycle.
- Flush has priority over all other events:
  - In WAIT: pulse div_annul_o for one cycle.
  - From any state: go to IDLE, clear pending_i2, suppress res_valid_o, deassert stall on the next cycle.
  - A div_ready_i arriving on the flush cycle is discarded.
- div_ready_i outside WAIT is ignored.
- rst mid-operation: return to the reset state immediately. No annul pulse is issued; the divider is reset in parallel.

Optional Feature:
- Macro DIV_TIMEOUT_EN.
- Defined:
  - A 6-bit counter clears at START and increments in WAIT.
  - When it reaches TIMEOUT without div_ready_i: pulse div_annul_o and timeout_o, deliver res_valid_o with hi = lo = 0, and continue as if from DONE (pending lane-2 work still runs).
- Not defined: no counter, timeout_o tied to 0, and WAIT is unbounded.

Test Plan:
- Lane-1 DIV with opa = 100, opb = 7, divider ready 32 cycles after start → one start pulse, res_valid_o with lane 0, hi = 2, lo = 14; stall high from request until the DONE cycle.
- Both lanes request: lane 1 DIVU 0xFFFFFFFF/16, lane 2 DIV -20/3 → two serialised starts; results lane 0 (hi = 15, lo = 0x0FFFFFFF) then lane 1 (hi = 0xFFFFFFFE, lo = 0xFFFFFFFA); stall drops only in the second DONE.
- Divisor 0 on lane 2 (opa = 0x1234) → no div_start_o; res_valid_o one cycle after the request with hi = 0x1234, lo = 0xFFFFFFFF.
- Flush in WAIT on the same cycle as div_ready_i → div_annul_o = 1, no res_valid_o, IDLE next cycle, stall low.
- Request held through DONE → exactly one start pulse; the next cycle is IDLE and the new instruction is accepted.
- DIV_TIMEOUT_EN with TIMEOUT = 40 and the divider never ready → annul and timeout_o on the 40th WAIT cycle, res_valid_o with hi = lo = 0.
